// File: rtl/tx_gearbox_66to32_pkg.sv
// Shared 64b/66b definitions for the tx gearbox and the rx header seeker / descrambler.
package tx_gearbox_66to32_pkg;
  localparam logic [1:0]  c_DATA_HEADER  = 2'b01;
  localparam logic [1:0]  c_CMD_HEADER   = 2'b10;
  localparam logic [1:0]  c_ERR_HEADER   = 2'b00;
  localparam logic [63:0] c_IDLE_PAYLOAD = 64'h1E00_0000_0000_0000;

  // x^58 + x^39 + 1: taps index the output-history register, newest bit at [0]
  localparam int c_SCR_LEN   = 58;
  localparam int c_SCR_TAP_A = 38;
  localparam int c_SCR_TAP_B = 57;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] payload;
  } block66_t;
endpackage

// File: rtl/tx_gearbox_66to32_scrambler.sv
// Parallel 64-bit self-synchronous scrambler; data_i[63] is the first bit in time.
module scrambler_64b
  import tx_gearbox_66to32_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);
  logic [c_SCR_LEN-1:0] state_q, state_d;

  always_comb begin
    logic [c_SCR_LEN-1:0] s;
    logic                 b;
    s      = state_q;
    data_o = '0;
    for (int i = 63; i >= 0; i--) begin
      b         = data_i[i] ^ s[c_SCR_TAP_A] ^ s[c_SCR_TAP_B];
      data_o[i] = b;
      s         = {s[c_SCR_LEN-2:0], b};
    end
    state_d = s;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     state_q <= '1;
    else if (en_i) state_q <= state_d;
  end
endmodule

// File: rtl/tx_gearbox_66to32.sv
// 66b-block to 32b-word transmit gearbox with idle insertion and header error injection.
module tx_gearbox_66to32
  import tx_gearbox_66to32_pkg::*;
#(
  parameter bit          P_SCRAMBLE     = 1'b1,
  parameter logic [63:0] P_IDLE_PAYLOAD = c_IDLE_PAYLOAD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] data_i,
  input  logic [1:0]  hdr_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  input  logic        word_en_i,
  input  logic        err_inject_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [15:0] idle_cnt_o
);
  logic [97:0] buf_q, buf_d, buf_ld;
  logic [6:0]  fill_q, fill_d;
  logic [31:0] word_q, word_d;
  logic        wvld_q;
  logic [15:0] idle_q;
  logic        pend_q, pend_d;

  logic        user_ld, idle_ld, ld;
  logic [63:0] raw_pl, scr_pl;
  block66_t    blk;

  assign data_ready_o = (fill_q < 7'd32);
  assign user_ld      = data_valid_i & data_ready_o;
  assign idle_ld      = word_en_i & data_ready_o & ~data_valid_i;
  assign ld           = user_ld | idle_ld;
  assign raw_pl       = user_ld ? data_i : P_IDLE_PAYLOAD;

  scrambler_64b u_scr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (ld),
    .data_i (raw_pl),
    .data_o (scr_pl)
  );

  always_comb begin
    blk.payload = P_SCRAMBLE ? scr_pl : raw_pl;
    blk.hdr     = pend_q ? c_ERR_HEADER : (user_ld ? hdr_i : c_CMD_HEADER);
    // loads only happen with fill < 32, so the shifted block never falls off the bottom
    buf_ld = ld ? (buf_q | ({blk, 32'd0} >> fill_q)) : buf_q;
    buf_d  = buf_ld;
    word_d = word_q;
    fill_d = fill_q + (ld ? 7'd66 : 7'd0) - (word_en_i ? 7'd32 : 7'd0);
    if (word_en_i) begin
      word_d = buf_ld[97:66];
      buf_d  = {buf_ld[65:0], 32'd0};
    end
    pend_d = (pend_q & ~ld) | (err_inject_i & ~pend_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q  <= '0;
      fill_q <= '0;
      word_q <= '0;
      wvld_q <= 1'b0;
      idle_q <= '0;
      pend_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      word_q <= word_d;
      wvld_q <= word_en_i;
      pend_q <= pend_d;
      if (idle_ld && idle_q != 16'hFFFF) idle_q <= idle_q + 16'd1;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = wvld_q;
  assign idle_cnt_o   = idle_q;
endmodule

// File: tb/tb_tx_gearbox_66to32.sv
// Directed bench for tx_gearbox_66to32: unscrambled instance for framing, scrambled one for the scrambler.
module tb_tx_gearbox_66to32;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] data = '0;
  logic [1:0]  hdr = 2'b01;
  logic        dv = 1'b0, we = 1'b0, err = 1'b0;
  logic        rdy, wvld;
  logic [31:0] word;
  logic [15:0] icnt;

  logic [63:0] s_data = '0;
  logic [1:0]  s_hdr = 2'b01;
  logic        s_dv = 1'b0, s_we = 1'b0, s_err = 1'b0;
  logic        s_rdy, s_wvld;
  logic [31:0] s_word;
  logic [15:0] s_icnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_gearbox_66to32 #(.P_SCRAMBLE(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .hdr_i(hdr), .data_valid_i(dv),
    .data_ready_o(rdy), .word_en_i(we), .err_inject_i(err), .word_o(word),
    .word_valid_o(wvld), .idle_cnt_o(icnt)
  );

  tx_gearbox_66to32 #(.P_SCRAMBLE(1'b1)) u_scr (
    .clk_i(clk), .rst_i(rst), .data_i(s_data), .hdr_i(s_hdr), .data_valid_i(s_dv),
    .data_ready_o(s_rdy), .word_en_i(s_we), .err_inject_i(s_err), .word_o(s_word),
    .word_valid_o(s_wvld), .idle_cnt_o(s_icnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; dv = 1'b0; we = 1'b0; err = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic strobe(input logic v, input logic [1:0] h, input logic [63:0] d);
    dv = v; hdr = h; data = d; we = 1'b1;
    tick();
    we = 1'b0; dv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (word !== 32'h0)  begin failures++; $display("FAIL reset_word got=%h exp=0", word); end
    checks++; if (wvld !== 1'b0)   begin failures++; $display("FAIL reset_wvld got=%b exp=0", wvld); end
    checks++; if (rdy !== 1'b1)    begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy); end
    checks++; if (icnt !== 16'h0)  begin failures++; $display("FAIL reset_icnt got=%h exp=0", icnt); end
  endtask

  task automatic test_idle_insert();
    logic [31:0] exp [3] = '{32'h8780_0000, 32'h0000_0000, 32'h21E0_0000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      repeat (7) tick();
      strobe(1'b0, 2'b01, 64'h0);
      checks++; if (word !== exp[i]) begin failures++; $display("FAIL idle_word%0d got=%h exp=%h", i, word, exp[i]); end
      checks++; if (wvld !== 1'b1)   begin failures++; $display("FAIL idle_wvld%0d got=%b exp=1", i, wvld); end
    end
    checks++; if (icnt !== 16'd2) begin failures++; $display("FAIL idle_cnt got=%0d exp=2", icnt); end
    tick();
    checks++; if (wvld !== 1'b0)  begin failures++; $display("FAIL idle_wvld_pulse got=%b exp=0", wvld); end
    checks++; if (word !== 32'h21E0_0000) begin failures++; $display("FAIL idle_word_hold got=%h exp=21e00000", word); end
  endtask

  task automatic test_data_ones();
    do_reset();
    strobe(1'b1, 2'b01, '1);
    checks++; if (word !== 32'h7FFF_FFFF) begin failures++; $display("FAIL ones_w0 got=%h exp=7fffffff", word); end
    tick();
    strobe(1'b0, 2'b01, '0);
    checks++; if (word !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ones_w1 got=%h exp=ffffffff", word); end
    strobe(1'b0, 2'b01, '0);
    checks++; if (word !== 32'hE1E0_0000) begin failures++; $display("FAIL ones_w2 got=%h exp=e1e00000", word); end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    do_reset();
    dv = 1'b1; hdr = 2'b01; data = 64'h0123_4567_89AB_CDEF; we = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (rdy) acc++;
      tick();
    end
    dv = 1'b0; we = 1'b0;
    checks++; if (acc !== 16)              begin failures++; $display("FAIL b2b_accepts got=%0d exp=16", acc); end
    checks++; if (icnt !== 16'd0)          begin failures++; $display("FAIL b2b_icnt got=%0d exp=0", icnt); end
    checks++; if (word !== 32'h89AB_CDEF)  begin failures++; $display("FAIL b2b_last got=%h exp=89abcdef", word); end
    checks++; if (rdy !== 1'b1)            begin failures++; $display("FAIL b2b_ready got=%b exp=1", rdy); end
    strobe(1'b0, 2'b01, '0);
    checks++; if (word !== 32'h8780_0000)  begin failures++; $display("FAIL b2b_empty got=%h exp=87800000", word); end
    checks++; if (icnt !== 16'd1)          begin failures++; $display("FAIL b2b_icnt1 got=%0d exp=1", icnt); end
  endtask

  task automatic test_fill_max();
    logic       r_exp [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] w_exp [3] = '{32'h0000_0001, 32'h0000_0000, 32'hDEAD_BEEF};
    do_reset();
    // each block accepted without a strobe then drained twice raises the residue by 2 bits
    for (int k = 0; k < 15; k++) begin
      dv = 1'b1; hdr = 2'b01; data = '0;
      tick();
      dv = 1'b0; we = 1'b1;
      tick(); tick();
      we = 1'b0;
    end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL max_ready30 got=%b exp=1", rdy); end
    dv = 1'b1; hdr = 2'b01; data = 64'h0000_0000_DEAD_BEEF;
    tick();
    dv = 1'b0;
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL max_ready96 got=%b exp=0", rdy); end
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 2'b01, '0);
      checks++; if (rdy !== r_exp[i])  begin failures++; $display("FAIL max_ready%0d got=%b exp=%b", i, rdy, r_exp[i]); end
      checks++; if (word !== w_exp[i]) begin failures++; $display("FAIL max_word%0d got=%h exp=%h", i, word, w_exp[i]); end
    end
  endtask

  task automatic test_err_inject();
    logic [31:0] exp [5] = '{32'h3FFF_FFFF, 32'hFFFF_FFFF, 32'hE1E0_0000, 32'h0000_0000, 32'h07FF_FFFF};
    logic        v   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    err = 1'b1; tick(); err = 1'b0; tick();
    err = 1'b1; tick(); err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe(v[i], 2'b01, '1);
      checks++; if (word !== exp[i]) begin failures++; $display("FAIL err_word%0d got=%h exp=%h", i, word, exp[i]); end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    strobe(1'b1, 2'b01, '1);
    rst = 1'b1; we = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0;
    checks++; if (word !== 32'h0) begin failures++; $display("FAIL mid_word got=%h exp=0", word); end
    checks++; if (wvld !== 1'b0)  begin failures++; $display("FAIL mid_wvld got=%b exp=0", wvld); end
    checks++; if (rdy !== 1'b1)   begin failures++; $display("FAIL mid_ready got=%b exp=1", rdy); end
    strobe(1'b0, 2'b01, '0);
    checks++; if (word !== 32'h8780_0000) begin failures++; $display("FAIL mid_fresh got=%h exp=87800000", word); end
  endtask

  task automatic test_scramble();
    do_reset();
    s_dv = 1'b1; s_hdr = 2'b01; s_data = '0; s_we = 1'b1;
    tick();
    s_dv = 1'b0; s_we = 1'b0;
    checks++; if (s_word !== 32'h4000_0000) begin failures++; $display("FAIL scr_w0 got=%h exp=40000000", s_word); end
    s_we = 1'b1;
    tick();
    s_we = 1'b0;
    checks++; if (s_word !== 32'h007F_FFF0) begin failures++; $display("FAIL scr_w1 got=%h exp=007ffff0", s_word); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_idle_insert();
    test_data_ones();
    test_back_to_back();
    test_fill_max();
    test_err_inject();
    test_reset_midop();
    test_scramble();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
